// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the hardwired ALU sequencer: state encoding,
// bus source codes, opcodes, instruction field positions and the ALU op mapping.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      T0    = 4'd1,
      T1    = 4'd2,
      T2    = 4'd3,
      T3    = 4'd4,
      T4    = 4'd5,
      T5    = 4'd6,
      T6    = 4'd7,
      HALT  = 4'd8,
      FAULT = 4'd9
   } state_t;

   localparam logic [4:0] SEL_R0  = 5'd0;
   localparam logic [4:0] SEL_HI  = 5'd16;
   localparam logic [4:0] SEL_LO  = 5'd17;
   localparam logic [4:0] SEL_ZHI = 5'd18;
   localparam logic [4:0] SEL_ZLO = 5'd19;
   localparam logic [4:0] SEL_PC  = 5'd20;
   localparam logic [4:0] SEL_MDR = 5'd21;

   localparam logic [4:0] OP_ADD  = 5'h00;
   localparam logic [4:0] OP_SUB  = 5'h01;
   localparam logic [4:0] OP_AND  = 5'h02;
   localparam logic [4:0] OP_OR   = 5'h03;
   localparam logic [4:0] OP_SHR  = 5'h04;
   localparam logic [4:0] OP_SHRA = 5'h05;
   localparam logic [4:0] OP_SHL  = 5'h06;
   localparam logic [4:0] OP_ROL  = 5'h09;
   localparam logic [4:0] OP_ROR  = 5'h0A;
   localparam logic [4:0] OP_MUL  = 5'h0C;
   localparam logic [4:0] OP_DIV  = 5'h0D;
   localparam logic [4:0] OP_NEG  = 5'h0E;
   localparam logic [4:0] OP_NOT  = 5'h0F;
   localparam logic [4:0] OP_HALT = 5'h1A;

   localparam int OP_W   = 5;
   localparam int REG_W  = 4;
   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   // ALU operation code for an opcode; reserved or out-of-range opcodes map to 0.
   function automatic logic [3:0] alu_map(input logic [OP_W-1:0] op);
      logic [3:0] res;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
         OP_ROL, OP_ROR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: res = op[3:0];
         default: res = 4'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath
// plus memory (slave).
interface alu_sequencer_if;
   logic        run;
   logic [31:0] ir;
   logic        mem_ready;
   logic [4:0]  BusDataSelect;
   logic [3:0]  GP_addr;
   logic        e_PC;
   logic        e_IR;
   logic        e_Y;
   logic        e_Z;
   logic        e_HI;
   logic        e_LO;
   logic        e_MDR;
   logic        e_MAR;
   logic        e_GP;
   logic        incPC;
   logic        MDR_read;
   logic [3:0]  ALU_op;
   logic        mem_read;
   logic        busy;
   logic        halted;
   logic        fault;

   modport master (
      input  run, ir, mem_ready,
      output BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR,
             e_MAR, e_GP, incPC, MDR_read, ALU_op, mem_read, busy, halted, fault
   );

   modport slave (
      output run, ir, mem_ready,
      input  BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR,
             e_MAR, e_GP, incPC, MDR_read, ALU_op, mem_read, busy, halted, fault
   );
endinterface

// File: rtl/alu_sequencer_decode.sv
// Opcode classifier: legality, unary/two-result flags, halt detection and the
// ALU operation code.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [OP_W-1:0] op,
   output logic            legal,
   output logic            unary,
   output logic            two_write,
   output logic            halt,
   output logic [3:0]      alu_op
);

   // Classify the opcode; reserved codes fall through as not legal.
   always_comb begin
      legal     = 1'b0;
      unary     = 1'b0;
      two_write = 1'b0;
      halt      = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
         OP_ROL, OP_ROR: legal = 1'b1;
         OP_MUL, OP_DIV: begin
            legal     = 1'b1;
            two_write = 1'b1;
         end
         OP_NEG, OP_NOT: begin
            legal = 1'b1;
            unary = 1'b1;
         end
         OP_HALT: halt = 1'b1;
         default: legal = 1'b0;
      endcase
      alu_op = legal ? alu_map(op) : 4'd0;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and register-to-register execute
// (T3-T5, T6 for mul/div), with a bounded memory-ready wait in T1.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
)
(
   input  logic             clock,
   input  logic             clear,
   alu_sequencer_if.master  bus
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t            state_r;
   state_t            state_nxt;
   logic [7:0]        wait_cnt_r;
   logic [7:0]        wait_cnt_nxt;
   logic              dec_legal;
   logic              dec_unary;
   logic              dec_two_write;
   logic              dec_halt;
   logic [3:0]        dec_alu_op;
   logic [REG_W-1:0]  ra;
   logic [REG_W-1:0]  rb;
   logic [REG_W-1:0]  rc;

   assign ra = bus.ir[RA_MSB:RA_LSB];
   assign rb = bus.ir[RB_MSB:RB_LSB];
   assign rc = bus.ir[RC_MSB:RC_LSB];

   alu_seq_decode u_decode (
      .op        (bus.ir[OP_MSB:OP_LSB]),
      .legal     (dec_legal),
      .unary     (dec_unary),
      .two_write (dec_two_write),
      .halt      (dec_halt),
      .alu_op    (dec_alu_op)
   );

   // State and T1 wait counter registers.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_r    <= IDLE;
         wait_cnt_r <= 8'd0;
      end else begin
         state_r    <= state_nxt;
         wait_cnt_r <= wait_cnt_nxt;
      end
   end

   // Next-state logic; the wait counter is nonzero only while lingering in T1.
   always_comb begin
      state_nxt    = state_r;
      wait_cnt_nxt = 8'd0;
      case (state_r)
         IDLE: state_nxt = bus.run ? T0 : IDLE;
         T0:   state_nxt = T1;
         T1: begin
            if (bus.mem_ready) begin
               state_nxt = T2;
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_nxt = FAULT;
            end else begin
               state_nxt    = T1;
               wait_cnt_nxt = wait_cnt_r + 8'd1;
            end
         end
         T2: state_nxt = T3;
         T3: begin
            if (dec_legal) begin
               state_nxt = T4;
            end else if (dec_halt) begin
               state_nxt = HALT;
            end else begin
               state_nxt = FAULT;
            end
         end
         T4: state_nxt = T5;
         T5: begin
            if (dec_two_write) begin
               state_nxt = T6;
            end else begin
               state_nxt = bus.run ? T0 : IDLE;
            end
         end
         T6:    state_nxt = bus.run ? T0 : IDLE;
         HALT:  state_nxt = HALT;
         FAULT: state_nxt = FAULT;
         default: state_nxt = FAULT;
      endcase
   end

   // Output decode of the current state (and the latched instruction in T3-T6).
   always_comb begin
      bus.BusDataSelect = SEL_R0;
      bus.GP_addr       = 4'd0;
      bus.e_PC          = 1'b0;
      bus.e_IR          = 1'b0;
      bus.e_Y           = 1'b0;
      bus.e_Z           = 1'b0;
      bus.e_HI          = 1'b0;
      bus.e_LO          = 1'b0;
      bus.e_MDR         = 1'b0;
      bus.e_MAR         = 1'b0;
      bus.e_GP          = 1'b0;
      bus.incPC         = 1'b0;
      bus.MDR_read      = 1'b0;
      bus.ALU_op        = 4'd0;
      bus.mem_read      = 1'b0;
      bus.busy          = 1'b1;
      bus.halted        = 1'b0;
      bus.fault         = 1'b0;
      case (state_r)
         IDLE: bus.busy = 1'b0;
         T0: begin
            bus.BusDataSelect = SEL_PC;
            bus.e_MAR         = 1'b1;
            bus.incPC         = 1'b1;
            bus.e_Z           = 1'b1;
         end
         T1: begin
            bus.BusDataSelect = SEL_ZLO;
            bus.e_PC          = (wait_cnt_r == 8'd0);
            bus.mem_read      = 1'b1;
            bus.MDR_read      = 1'b1;
            bus.e_MDR         = bus.mem_ready;
         end
         T2: begin
            bus.BusDataSelect = SEL_MDR;
            bus.e_IR          = 1'b1;
         end
         T3: begin
            if (dec_legal) begin
               bus.BusDataSelect = {1'b0, rb};
               bus.e_Y           = 1'b1;
            end else begin
               bus.BusDataSelect = SEL_R0;
            end
         end
         T4: begin
            bus.BusDataSelect = dec_unary ? {1'b0, rb} : {1'b0, rc};
            bus.e_Z           = 1'b1;
            bus.ALU_op        = dec_alu_op;
         end
         T5: begin
            bus.BusDataSelect = SEL_ZLO;
            if (dec_two_write) begin
               bus.e_LO = 1'b1;
            end else begin
               bus.e_GP    = 1'b1;
               bus.GP_addr = ra;
            end
         end
         T6: begin
            bus.BusDataSelect = SEL_ZHI;
            bus.e_HI          = 1'b1;
         end
         HALT: begin
            bus.busy   = 1'b0;
            bus.halted = 1'b1;
         end
         FAULT: begin
            bus.busy  = 1'b0;
            bus.fault = 1'b1;
         end
         default: bus.busy = 1'b0;
      endcase
   end

endmodule
